uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter: DEPTH, 16, FIFO entries (power of two, >= 2).
REQ-002 SHALL have parameter: WIDTH, 8, data word width (matches uart_tx data port).
REQ-003 SHALL have port: clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port: rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: wr_data  in  WIDTH  word to enqueue.
REQ-006 SHALL have port: wr_valid  in  1  producer offers wr_data.
REQ-007 SHALL have port: wr_ready  out  1  FIFO not full; a write occurs when wr_valid && wr_ready.
REQ-008 SHALL have port: tx_data  out  WIDTH  head word, to uart_tx data.
REQ-009 SHALL have port: tx_send  out  1  send request, to uart_tx send.
REQ-010 SHALL have port: tx_ready  in  1  uart_tx idle indication.
REQ-011 SHALL have port: empty  out  1  FIFO holds no words and the transmitter is idle.
REQ-012 SHALL have port (only when UART_TX_FIFO_LEVEL_EN is defined): level  out  $clog2(DEPTH)+1  stored word count.

Function
REQ-013 SHALL store words in a circular buffer with read/write pointers one bit wider than $clog2(DEPTH); full = MSBs differ and low bits equal; empty = pointers equal.
REQ-014 SHALL run a drain FSM with states IDLE, REQ, BUSY.
REQ-015 IDLE -> REQ when the FIFO is non-empty and tx_ready=1; tx_send asserts in the first REQ cycle.
REQ-016 SHALL hold tx_send=1 throughout REQ; REQ -> BUSY on the first cycle tx_ready=0 (tx_send drops the same edge).
REQ-017 BUSY -> IDLE when tx_ready returns to 1; the head word SHALL be popped (read pointer +1) on that transition.
REQ-018 SHALL drive tx_data from the head entry and keep it stable from REQ entry until the pop.
REQ-019 Write-to-tx_send latency from an empty, idle FIFO SHALL be 2 cycles (write edge, IDLE->REQ edge).
REQ-020 Simultaneous write and pop SHALL both take effect; the count stays unchanged.
REQ-021 A write while full SHALL be impossible (wr_ready=0); the stored data is unaffected.
REQ-022 Pointers SHALL wrap modulo 2*DEPTH with no special casing.
REQ-023 A word written during BUSY SHALL be sent in order after the current word without gaps beyond the IDLE cycle.
REQ-024 empty SHALL be 1 only when the state is IDLE and the count is 0.

Reset
REQ-025 Asserting rst (low) SHALL immediately clear both pointers, force the state to IDLE, and drive tx_send=0, wr_ready=1, empty=1, and level=0; tx_data is don't-care.
REQ-026 Reset mid-transmission SHALL discard all queued words; after rst releases, no tx_send until a new write.
REQ-027 Storage array SHALL NOT require reset.

Configuration
REQ-028 Macro UART_TX_FIFO_LEVEL_EN defined: SHALL add the level port, equal to write pointer minus read pointer, updated the same cycle as the pointers.
REQ-029 Macro undefined: SHALL omit the level port and its logic; all other behaviour is identical.

Structure
REQ-030 A shared package uart_pkg SHALL hold the FSM state typedef (IDLE/REQ/BUSY) and the default WIDTH constant.
REQ-031 Storage and pointers SHALL be one sub-module, uart_fifo_mem (write port plus combinational head read); the FSM lives in uart_tx_fifo.

Verification
REQ-032 Bench SHALL cover a reset release with no writes -> tx_send=0, empty=1, and wr_ready=1 for 1000 cycles.
REQ-033 Bench SHALL cover a write of 8'hAA with a uart_tx model whose ready drops 3 cycles after send -> tx_send=1 two cycles after the write, held until ready=0, and tx_data=8'hAA throughout.
REQ-034 Bench SHALL cover writing 8'h00..8'h0F back-to-back (DEPTH=16) with tx_ready held 0 -> wr_ready=0 after the 16th write; the 17th offer is stalled; level=16 with the macro defined.
REQ-035 Bench SHALL cover draining 20 words through the wrap -> the bytes reach uart_tx in write order with none lost or duplicated.
REQ-036 Bench SHALL cover a write on the same edge as a pop with 4 words stored -> the count stays 4 and the next word sent is the second-oldest.
REQ-037 Bench SHALL cover rst asserted during BUSY with 5 words queued -> tx_send=0 and empty=1 immediately, and no send after release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: drain FSM state encoding and the default data width.
package uart_pkg;

  localparam int UART_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2
  } tx_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Circular word buffer with one-bit-wider pointers, a write port and a combinational head read.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = UART_WIDTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // NOTE: the storage array is deliberately left out of reset; only the pointers
  // define which entries are valid, so clearing the data would buy nothing.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Pointers run modulo 2*DEPTH; the extra MSB tells full from empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count     = wr_ptr - rd_ptr;
  assign head_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO feeding a uart_tx: buffers words and hands them out with a send/ready handshake.
// Define UART_TX_FIFO_LEVEL_EN to add the 'level' occupancy output.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = UART_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_send,
  input  logic             tx_ready,
  output logic             empty
`ifdef UART_TX_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level
`endif
);

  localparam int AW = $clog2(DEPTH);

  tx_state_t   state;
  logic        full;
  logic        wr_en;
  logic        pop;
  logic [AW:0] count;

  assign wr_ready = !full;
  assign wr_en    = wr_valid && !full;
  // The head leaves the buffer only once the transmitter reports idle again.
  assign pop      = (state == BUSY) && tx_ready;

  uart_fifo_mem #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) u_mem (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .head_data(tx_data),
    .full     (full),
    .count    (count)
  );

  // NOTE: state and tx_send are registers, so they take non-blocking assignments;
  // every reader then sees the pre-edge value regardless of evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      tx_send <= 1'b0;
    end else begin
      case (state)
        IDLE: if ((count != '0) && tx_ready) begin
          state   <= REQ;
          tx_send <= 1'b1;
        end
        REQ: if (!tx_ready) begin
          state   <= BUSY;
          tx_send <= 1'b0;
        end
        BUSY: if (tx_ready) state <= IDLE;
        default: begin
          state   <= IDLE;
          tx_send <= 1'b0;
        end
      endcase
    end
  end

  assign empty = (state == IDLE) && (count == '0);

`ifdef UART_TX_FIFO_LEVEL_EN
  assign level = count;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a queue-based reference plus a behavioural uart_tx partner.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic [WIDTH-1:0] tx_data;
  logic             tx_send;
  logic             tx_ready;
  logic             empty;
`ifdef UART_TX_FIFO_LEVEL_EN
  logic [4:0]       level;
`endif

  uart_tx_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_data (wr_data),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .tx_data (tx_data),
    .tx_send (tx_send),
    .tx_ready(tx_ready),
    .empty   (empty)
`ifdef UART_TX_FIFO_LEVEL_EN
    ,
    .level   (level)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: fifo_q holds every accepted word until the transmitter has finished with it.
  typedef enum {M_IDLE, M_WAIT, M_BUSY} mphase_t;

  logic [7:0] fifo_q[$];
  logic [7:0] sent_log[$];
  mphase_t    ph = M_IDLE;
  int         cnt = 0;
  int         drop_delay = 3;
  int         busy_len = 4;
  int         n_written = 0;
  bit         arm = 1'b0;
  bit         pop_pend = 1'b0;
  bit         hold_low = 1'b0;
  bit         rand_timing = 1'b0;
  logic [7:0] cur = 8'h00;

  // Runs once per falling edge: checks the outputs and plays the uart_tx partner.
  task automatic model_negedge();
    logic [7:0] head;
    head = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    check("wr_ready", 32'(wr_ready), 32'(fifo_q.size() < DEPTH));
    check("empty", 32'(empty), 32'(fifo_q.size() == 0));
`ifdef UART_TX_FIFO_LEVEL_EN
    check("level", 32'(level), 32'(fifo_q.size()));
`endif
    case (ph)
      M_IDLE: begin
        check("tx_send_idle", 32'(tx_send), 32'(arm));
        if (tx_send === 1'b1) begin
          cur = tx_data;
          check("tx_order", 32'(tx_data), 32'(head));
          sent_log.push_back(tx_data);
          if (rand_timing) begin
            drop_delay = $urandom_range(1, 3);
            busy_len   = $urandom_range(1, 4);
          end
          cnt = drop_delay;
          ph  = M_WAIT;
          arm = 1'b0;
        end else begin
          tx_ready = !hold_low;
          arm      = (fifo_q.size() > 0) && !hold_low;
        end
      end
      M_WAIT: begin
        check("tx_send_hold", 32'(tx_send), 32'd1);
        check("tx_data_req", 32'(tx_data), 32'(cur));
        cnt--;
        if (cnt == 0) begin
          tx_ready = 1'b0;
          ph       = M_BUSY;
          cnt      = busy_len;
        end
      end
      M_BUSY: begin
        check("tx_send_busy", 32'(tx_send), 32'd0);
        check("tx_data_busy", 32'(tx_data), 32'(cur));
        cnt--;
        if (cnt == 0) begin
          tx_ready = 1'b1;
          ph       = M_IDLE;
          pop_pend = 1'b1;
          arm      = 1'b0;
        end
      end
      default: ph = M_IDLE;
    endcase
  endtask

  task automatic step();
    bit         do_wr;
    logic [7:0] d;
    do_wr = wr_valid && (fifo_q.size() < DEPTH);
    d     = wr_data;
    @(posedge clk);
    if (pop_pend) begin
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      pop_pend = 1'b0;
    end
    if (do_wr && rst) begin
      fifo_q.push_back(d);
      n_written++;
    end
    @(negedge clk);
    model_negedge();
  endtask

  task automatic model_clear();
    fifo_q.delete();
    ph       = M_IDLE;
    pop_pend = 1'b0;
    arm      = 1'b0;
    wr_valid = 1'b0;
    tx_ready = !hold_low;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((fifo_q.size() > 0 || ph != M_IDLE || pop_pend) && k < budget) begin
      step();
      k++;
    end
    check("drain_timeout", 32'(k < budget), 32'd1);
  endtask

  task automatic write_word(input logic [7:0] d);
    wr_data  = d;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_tx_send"}, 32'(tx_send), 32'd0);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
`ifdef UART_TX_FIFO_LEVEL_EN
    check({tag, "_level"}, 32'(level), 32'd0);
`endif
  endtask

  typedef struct {
    logic       vld;
    logic [7:0] data;
    logic       exp_ready;
    logic       exp_empty;
    int         exp_cnt;
  } vec_t;

  initial begin
    vec_t vecs[18];
    int   base;
    int   k;
    int   w0;

    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    tx_ready = 1'b1;
    #2 rst = 1'b0;
    #1 reset_checks("por");
    model_clear();
    @(negedge clk);
    repeat (3) step();
    rst = 1'b1;

    // Idle after reset release: nothing may be sent.
    base = sent_log.size();
    repeat (1000) step();
    check("idle_no_send", 32'(sent_log.size() - base), 32'd0);

    // Single word with a transmitter that drops ready three cycles after the send.
    drop_delay = 3;
    busy_len   = 5;
    base = sent_log.size();
    write_word(8'hAA);
    check("aa_lat1", 32'(tx_send), 32'd0);
    step();
    check("aa_lat2", 32'(tx_send), 32'd1);
    check("aa_data", 32'(tx_data), 32'hAA);
    k = 0;
    while (ph == M_WAIT && k < 20) begin
      check("aa_hold", 32'(tx_send), 32'd1);
      step();
      k++;
    end
    step();
    check("aa_drop", 32'(tx_send), 32'd0);
    check("aa_data_busy", 32'(tx_data), 32'hAA);
    drain(100);
    check("aa_count", 32'(sent_log.size() - base), 32'd1);
    check("aa_byte", 32'(sent_log[base]), 32'hAA);

    // Fill to full with the transmitter held busy, then offer one more word.
    hold_low = 1'b1;
    tx_ready = 1'b0;
    arm      = 1'b0;
    vecs[0] = '{1'b0, 8'h55, 1'b1, 1'b1, 0};
    for (int i = 1; i <= 16; i++) vecs[i] = '{1'b1, 8'(i - 1), (i < 16), 1'b0, i};
    vecs[17] = '{1'b1, 8'h10, 1'b0, 1'b0, 16};
    for (int i = 0; i < 18; i++) begin
      wr_valid = vecs[i].vld;
      wr_data  = vecs[i].data;
      step();
      wr_valid = 1'b0;
      check($sformatf("fill%0d_wr_ready", i), 32'(wr_ready), 32'(vecs[i].exp_ready));
      check($sformatf("fill%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
`ifdef UART_TX_FIFO_LEVEL_EN
      check($sformatf("fill%0d_level", i), 32'(level), 32'(vecs[i].exp_cnt));
`endif
    end
    hold_low = 1'b0;
    base = sent_log.size();
    drain(1000);
    check("fill_sent", 32'(sent_log.size() - base), 32'd16);
    for (int j = 0; j < 16; j++) check($sformatf("fill_byte%0d", j), 32'(sent_log[base + j]), 32'(j));

    // Random traffic and timing across pointer wrap.
    rand_timing = 1'b1;
    base = sent_log.size();
    w0   = n_written;
    for (int i = 0; i < 800; i++) begin
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_data  = 8'($urandom);
      step();
    end
    wr_valid = 1'b0;
    drain(2000);
    check("rand_count", 32'(sent_log.size() - base), 32'(n_written - w0));
    rand_timing = 1'b0;

    // Write on the same edge as the pop, with four words stored.
    drop_delay = 2;
    busy_len   = 4;
    hold_low   = 1'b1;
    tx_ready   = 1'b0;
    arm        = 1'b0;
    write_word(8'hA0);
    write_word(8'hA1);
    write_word(8'hA2);
    write_word(8'hA3);
    hold_low = 1'b0;
    k = 0;
    while (!pop_pend && k < 60) begin
      step();
      k++;
    end
    check("pop_wait_timeout", 32'(k < 60), 32'd1);
    base = sent_log.size();
    write_word(8'hB4);
`ifdef UART_TX_FIFO_LEVEL_EN
    check("same_edge_level", 32'(level), 32'd4);
`endif
    check("same_edge_wr_ready", 32'(wr_ready), 32'd1);
    drain(500);
    check("same_edge_sent", 32'(sent_log.size() - base), 32'd4);
    check("same_edge_next", 32'(sent_log[base]), 32'hA1);
    check("same_edge_b1", 32'(sent_log[base + 1]), 32'hA2);
    check("same_edge_b2", 32'(sent_log[base + 2]), 32'hA3);
    check("same_edge_b3", 32'(sent_log[base + 3]), 32'hB4);

    // Reset while BUSY with five words queued.
    drop_delay = 1;
    busy_len   = 10;
    hold_low   = 1'b1;
    tx_ready   = 1'b0;
    arm        = 1'b0;
    for (int i = 0; i < 5; i++) write_word(8'hC0 + 8'(i));
    hold_low = 1'b0;
    k = 0;
    while (ph != M_BUSY && k < 40) begin
      step();
      k++;
    end
    check("busy_wait_timeout", 32'(k < 40), 32'd1);
    step();
    step();
    base = sent_log.size();
    rst = 1'b0;
    #1 reset_checks("mid_rst");
    model_clear();
    repeat (3) step();
    rst = 1'b1;
    repeat (60) step();
    check("post_rst_sends", 32'(sent_log.size() - base), 32'd0);

    // The FIFO still works after the mid-transmission reset.
    base = sent_log.size();
    write_word(8'h5A);
    drain(100);
    check("post_rst_count", 32'(sent_log.size() - base), 32'd1);
    check("post_rst_byte", 32'(sent_log[base]), 32'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
